// File: rtl/sal_addr_pkg.sv
// Address-map types and field decoders shared by the bank request router and its FIFOs.
// Decoders take geometry as arguments so one package serves every instance width.
package sal_addr_pkg;

    typedef enum logic [1:0] {
        MAP_ROW_BANK_COL  = 2'd0,
        MAP_BANK_ROW_COL  = 2'd1,
        MAP_ROW_XBANK_COL = 2'd2
    } map_mode_e;

    localparam int DEF_ID_W  = 4;
    localparam int DEF_RA_W  = 14;
    localparam int DEF_CA_W  = 10;
    localparam int DEF_LEN_W = 4;

    // Default-geometry request record; the router re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_RA_W-1:0]  ra;
        logic [DEF_CA_W-1:0]  ca;
        logic [DEF_LEN_W-1:0] len;
        logic                 wr;
    } bk_req_t;

    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] get_col(input logic [63:0] addr, input int ofs_w, input int ca_w);
        return addr_field(addr, ofs_w, ca_w);
    endfunction

    function automatic logic [63:0] get_row(input logic [63:0] addr, input map_mode_e mode,
                                            input int ofs_w, input int ba_w,
                                            input int ra_w, input int ca_w);
        if (mode == MAP_BANK_ROW_COL) begin
            return addr_field(addr, ofs_w + ca_w, ra_w);
        end
        return addr_field(addr, ofs_w + ca_w + ba_w, ra_w);
    endfunction

    function automatic logic [63:0] get_bank(input logic [63:0] addr, input map_mode_e mode,
                                             input int ofs_w, input int ba_w,
                                             input int ra_w, input int ca_w);
        logic [63:0] bank;
        case (mode)
            MAP_BANK_ROW_COL:  bank = addr_field(addr, ofs_w + ca_w + ra_w, ba_w);
            MAP_ROW_XBANK_COL: bank = addr_field(addr, ofs_w + ca_w, ba_w)
                                    ^ addr_field(get_row(addr, mode, ofs_w, ba_w, ra_w, ca_w), 0, ba_w);
            default:           bank = addr_field(addr, ofs_w + ca_w, ba_w);
        endcase
        return bank;
    endfunction

endpackage

// File: rtl/sal_req_fifo.sv
// Per-bank request queue: push visible at head next cycle, no bypass; full/empty registered.
// Push is dropped when full (a same-cycle pop does not make room), pop ignored when empty.
module sal_req_fifo
    import sal_addr_pkg::*;
#(
    parameter type req_t = bk_req_t,
    parameter int  DEPTH = 2,
    parameter int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  req_t             push_dat_i,
    input  logic             pop_i,
    output req_t             head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d   = (cnt_d == CNT_W'(DEPTH));
        empty_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/sal_bank_req_router.sv
// Decodes AXI address requests into per-bank FIFOs; request visible to its bank one cycle after accept.
// aready drops only when the target bank FIFO is full, so a busy bank never blocks the others.
module sal_bank_req_router
    import sal_addr_pkg::*;
#(
    parameter int BK_CNT   = 4,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int LEN_W    = 4,
    parameter int RA_W     = 14,
    parameter int CA_W     = 10,
    parameter int OFS_W    = 3,
    parameter int DEPTH    = 2,
    parameter int MAP_MODE = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      avalid,
    output logic                                      aready,
    input  logic [ID_W-1:0]                           aid,
    input  logic [ADDR_W-1:0]                         aaddr,
    input  logic [LEN_W-1:0]                          alen,
    input  logic                                      awr,
    output logic [BK_CNT-1:0]                         bk_valid,
    input  logic [BK_CNT-1:0]                         bk_ready,
    output logic [BK_CNT-1:0][ID_W-1:0]               bk_id,
    output logic [BK_CNT-1:0][RA_W-1:0]               bk_ra,
    output logic [BK_CNT-1:0][CA_W-1:0]               bk_ca,
    output logic [BK_CNT-1:0][LEN_W-1:0]              bk_len,
    output logic [BK_CNT-1:0]                         bk_wr,
    output logic [BK_CNT-1:0][$clog2(DEPTH+1)-1:0]    bk_cnt
);
    localparam int        BA_W  = $clog2(BK_CNT);
    localparam int        CNT_W = $clog2(DEPTH + 1);
    localparam map_mode_e MODE  = map_mode_e'(MAP_MODE);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [RA_W-1:0]  ra;
        logic [CA_W-1:0]  ca;
        logic [LEN_W-1:0] len;
        logic             wr;
    } req_t;

    logic [63:0]       addr_ext;
    logic [BA_W-1:0]   bank;
    req_t              req_in;
    logic [BK_CNT-1:0] full;
    logic [BK_CNT-1:0] empty;
    logic [BK_CNT-1:0] push;
    req_t              head [BK_CNT];

    assign addr_ext   = 64'(aaddr);
    assign bank       = BA_W'(get_bank(addr_ext, MODE, OFS_W, BA_W, RA_W, CA_W));
    assign req_in.id  = aid;
    assign req_in.ra  = RA_W'(get_row(addr_ext, MODE, OFS_W, BA_W, RA_W, CA_W));
    assign req_in.ca  = CA_W'(get_col(addr_ext, OFS_W, CA_W));
    assign req_in.len = alen;
    assign req_in.wr  = awr;

    // Registered full flag keeps bk_ready off the aready path.
    assign aready = !rst && !full[bank];

    for (genvar i = 0; i < BK_CNT; i++) begin : g_bank
        assign push[i] = avalid && aready && (bank == BA_W'(i));

        sal_req_fifo #(
            .req_t (req_t),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (push[i]),
            .push_dat_i (req_in),
            .pop_i      (bk_ready[i]),
            .head_dat_o (head[i]),
            .full_o     (full[i]),
            .empty_o    (empty[i]),
            .cnt_o      (bk_cnt[i])
        );

        assign bk_valid[i] = !empty[i];
        assign bk_id[i]    = head[i].id;
        assign bk_ra[i]    = head[i].ra;
        assign bk_ca[i]    = head[i].ca;
        assign bk_len[i]   = head[i].len;
        assign bk_wr[i]    = head[i].wr;
    end

endmodule

// File: doc/sal_bank_req_router.md
# sal_bank_req_router

Parametrised address decoder that routes AXI address-channel requests to per-bank request queues. It decodes bank, row and column from the request address using a selectable mapping mode. It buffers each request in a per-bank FIFO so one busy bank does not block requests to the other banks. It sits between the AXI address channel and the bank controllers, and replaces the single-bank pass-through decoder.

## Interface
Parameters:
- BK_CNT, 4: number of banks; power of 2, ≥2
- ADDR_W, 32: AXI address width
- ID_W, 4: AXI ID width
- LEN_W, 4: AXI burst length width
- RA_W, 14: row address width
- CA_W, 10: column address width
- OFS_W, 3: byte-offset bits dropped from the address LSBs
- DEPTH, 2: per-bank FIFO depth; power of 2, ≥2
- MAP_MODE, 0: address map
  - 0 = row|bank|col
  - 1 = bank|row|col
  - 2 = row|bank^row[BA_W-1:0]|col

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- avalid  in  1  request valid
- aready  out  1  request accepted this cycle when avalid is also high
- aid  in  ID_W  request ID
- aaddr  in  ADDR_W  byte address
- alen  in  LEN_W  burst length
- awr  in  1  1 = write request, 0 = read request
- bk_valid  out  [BK_CNT]  per-bank request valid
- bk_ready  in  [BK_CNT]  per-bank ready
- bk_id  out  [BK_CNT][ID_W]  request ID to each bank
- bk_ra  out  [BK_CNT][RA_W]  row address to each bank
- bk_ca  out  [BK_CNT][CA_W]  column address to each bank
- bk_len  out  [BK_CNT][LEN_W]  burst length to each bank
- bk_wr  out  [BK_CNT]  write flag to each bank
- bk_cnt  out  [BK_CNT][$clog2(DEPTH+1)]  FIFO occupancy per bank

## Operation
- BA_W = $clog2(BK_CNT).
- Field extraction uses the address after dropping OFS_W LSBs:
  - col = lowest CA_W bits.
  - MAP_MODE 0: bank = next BA_W bits, row = next RA_W bits.
  - MAP_MODE 1: row = next RA_W bits, bank = next BA_W bits.
  - MAP_MODE 2: same fields as mode 0, then bank ^= row[BA_W-1:0].
- Unused upper address bits are ignored.
- Decode is combinational on aaddr. aready = !rst && !full[bank].
- Push: when avalid && aready, {aid, row, col, alen, awr} is written into FIFO[bank]. No other FIFO changes.
- Pop: when bk_valid[i] && bk_ready[i], the head of FIFO[i] is removed.
- bk_valid[i] = !empty[i]. bk_* data always shows the FIFO[i] head. Data is don't-care when empty, but must not be X after reset (storage is reset to 0).
- Push and pop on the same bank in the same cycle is legal whenever not full; occupancy is unchanged.
- When FIFO[i] is full, a pop in that cycle does not enable a same-cycle push. aready uses the registered full flag, so there is no ready-to-ready combinational path.
- Ordering: FIFO order is kept per bank. There is no ordering guarantee across banks.
- avalid with a full target bank leaves aready = 0. The requester must hold its request stable (AXI rule); no bank state changes.
- Reset mid-operation: all FIFOs are emptied and queued requests are discarded. Any in-flight handshake on that cycle is ignored.

## Timing
- Reset values:
  - aready = 0 while rst is high.
  - bk_valid = 0, bk_cnt = 0, all bk_* data = 0.
- Latency: a request accepted in cycle N appears on bk_valid in cycle N+1. There is no bypass path.
- Throughput: 1 request per cycle into distinct or non-full banks. Each bank drains 1 request per cycle.
- Full and empty flags are registered. Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH+1) bits wide and saturates only by construction.
- First cycle after rst deasserts: aready = 1 for any address.

## Structure
- Package sal_addr_pkg holds:
  - map_mode_e enum.
  - bk_req_t struct {id, ra, ca, len, wr}.
  - get_bank, get_row, get_col functions, parametrised via the MAP_MODE argument.
- Sub-module sal_req_fifo: one bk_req_t FIFO of DEPTH entries with push, pop, full, empty and count. It is instantiated BK_CNT times in a generate loop.
- The top level holds decode, the aready mux, push demux, and port flattening.

## Test plan
- Reset, then a request with MAP_MODE=0, BK_CNT=4, aaddr=0x0000_2468 -> next cycle bk_valid[bank]=1, where col = 0x0000_2468>>3 & 0x3FF; the other three bk_valid stay 0.
- Same aaddr under MAP_MODE 1 and MAP_MODE 2 -> bank, row and col match the sal_addr_pkg functions. In mode 2, a row with row[1:0]=2'b11 flips bank 0 to 3.
- Bank 1 held with bk_ready[1]=0 and DEPTH=2: three back-to-back bank-1 requests -> 2 accepted, third sees aready=0, bk_cnt[1]=2. A bank-2 request in that cycle is accepted.
- Full bank 1, bk_ready[1]=1 for one cycle -> bk_cnt[1] goes 2→1 and aready for bank 1 returns high the next cycle. The first-pushed ID pops first.
- Continuous push and pop on bank 0 at one per cycle for 8 cycles -> bk_cnt[0] stays at 1, and IDs emerge in order 0..7 across pointer wrap.
- rst asserted with 2 entries in bank 3 and avalid high -> next cycle all bk_valid=0, bk_cnt=0, aready=0 during rst, and the request is not enqueued.
